veriyolu_hakem: RTL and testbench
=================================

# veriyolu_hakem

Two-requester round-robin arbiter that shares the single peripheral bus port (UART/SPI/PWM Wishbone master) between requester 0 (core data-memory path) and requester 1 (secondary master, e.g. debug/DMA). Sits between the requesters and the Wishbone master. Holds the grant for a whole transaction and inserts the mandatory idle cycle between transactions. Flags transactions that exceed a cycle budget.

## Interface
Parameters:
- ZAMAN_ASIMI, 255: cycles in AKTIF after which a transaction is flagged as timed out; 1..255.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock; reset is asynchronous and active-low
- m0_adres_i / m1_adres_i  in  32  requester address
- m0_veri_i / m1_veri_i  in  32  write data
- m0_veri_maske_i / m1_veri_maske_i  in  4  byte mask
- m0_yaz_gecerli_i / m1_yaz_gecerli_i  in  1  1 = write, 0 = read
- m0_sec_i / m1_sec_i  in  1  request valid; held with stable fields until accepted
- m0_veri_o / m1_veri_o  out  32  read data, valid in the requester's completion cycle
- m0_durdur_o / m1_durdur_o  out  1  stall; request accepted in a cycle where sec=1 and durdur=0
- vy_adres_o, vy_veri_o, vy_veri_maske_o, vy_yaz_gecerli_o  out  32/32/4/1  to Wishbone master
- vy_sec_o  out  1  select to Wishbone master
- vy_veri_i  in  32  read data from Wishbone master
- vy_durdur_i  in  1  stall from Wishbone master
- hata_o  out  1  sticky timeout flag
- hata_sahip_o  out  1  requester index of the first timed-out transaction

## Operation
- States: BOS (idle/arbitrate), AKTIF (forward granted requester).
- BOS: vy_sec_o=0. If any mK_sec_i=1: grant to requester at `oncelik` if it requests, else the other; register `sahip`; go AKTIF. Stay in BOS if none request.
- AKTIF: vy_* outputs = fields of requester `sahip`; vy_sec_o=1. Completion when vy_durdur_i=0. On completion: go BOS; `oncelik` <= ~sahip.
- Stall: mK_durdur_o = mK_sec_i & ~(state==AKTIF & sahip==K & ~vy_durdur_i). Combinational.
- Read data: mK_veri_o = vy_veri_i when sahip==K, else 0.
- In BOS, vy_adres_o/vy_veri_o/mask/yaz are 0.
- Requester drops sec mid-transaction: this is illegal. The arbiter ignores it and completes the transaction downstream.
- Timeout: 8-bit `sayac` clears on entering AKTIF and increments each AKTIF cycle, saturating. When `sayac`==ZAMAN_ASIMI and hata_o=0: set hata_o=1 and hata_sahip_o=sahip. The transaction is not aborted. hata_o clears only on reset.

## Timing
- Reset values: state=BOS, oncelik=0, sahip=0, sayac=0, vy_sec_o=0, hata_o=0, hata_sahip_o=0. mK_durdur_o equals mK_sec_i during reset.
- Asynchronous reset mid-transaction drops vy_sec_o immediately. The requester stays stalled and re-arbitrates after release.
- Request first visible in cycle N (BOS) -> vy_sec_o=1 in N+1 -> earliest completion N+2 (ack from Wishbone slave in N+2).
- At least one BOS cycle with vy_sec_o=0 between any two transactions. The Wishbone master detects new transactions only on a rising edge of sec.
- Simultaneous requests in BOS: `oncelik` wins. Back-to-back from both requesters alternates 0,1,0,1…
- Single requester: wins every arbitration. Throughput is 1 transaction per 3 cycles at zero slave wait.
- hata_o rises in the cycle after `sayac` reaches ZAMAN_ASIMI.

## Structure
- State encodings (BOS/AKTIF) and the ZAMAN_ASIMI default go in the shared tanimlamalar.vh.
- No sub-module is required. The 2-way round-robin pick is inline combinational logic.

## Test plan
- Reset, then m0 read 0x20000004 with slave ack 1 cycle after vy_sec_o -> m0_durdur_o high for 2 cycles, low in completion cycle, m0_veri_o=slave data 0xA5A5_0001.
- m0 and m1 assert sec in the same cycle, oncelik=0 -> m0 served first; m1 stalled throughout; m1 served next with vy_sec_o low for exactly 1 cycle between transactions.
- Both requesters continuously issue 4 writes each -> vy_adres_o owner alternates 0,1,0,1…; every vy_sec_o rise is preceded by a 0 cycle.
- ZAMAN_ASIMI=4, slave never acks for 10 cycles on m1 -> hata_o=1 in the cycle after sayac reaches 4, hata_sahip_o=1; transaction still completes on late ack; hata_o stays 1.
- Assert rst_ni low mid-AKTIF -> vy_sec_o=0 asynchronously, hata_o=0; after release the held m0 request is re-granted and completes.

Source files
------------

// File: rtl/veriyolu_hakem_pkg.sv
// Shared definitions for the two-requester peripheral bus arbiter:
// FSM state encoding and the default transaction timeout budget.
package veriyolu_hakem_pkg;

  typedef enum logic {
    BOS   = 1'b0,
    AKTIF = 1'b1
  } durum_e;

  localparam int unsigned ZAMAN_ASIMI_VARSAYILAN = 255;

endpackage

// File: rtl/veriyolu_hakem.sv
// Two-requester round-robin arbiter in front of the peripheral Wishbone master.
// Holds the grant for a whole transaction and flags transactions that run too long.
module veriyolu_hakem
  import veriyolu_hakem_pkg::*;
#(
  parameter int unsigned ZAMAN_ASIMI = ZAMAN_ASIMI_VARSAYILAN
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] m0_adres_i,
  input  logic [31:0] m0_veri_i,
  input  logic [3:0]  m0_veri_maske_i,
  input  logic        m0_yaz_gecerli_i,
  input  logic        m0_sec_i,
  output logic [31:0] m0_veri_o,
  output logic        m0_durdur_o,
  input  logic [31:0] m1_adres_i,
  input  logic [31:0] m1_veri_i,
  input  logic [3:0]  m1_veri_maske_i,
  input  logic        m1_yaz_gecerli_i,
  input  logic        m1_sec_i,
  output logic [31:0] m1_veri_o,
  output logic        m1_durdur_o,
  output logic [31:0] vy_adres_o,
  output logic [31:0] vy_veri_o,
  output logic [3:0]  vy_veri_maske_o,
  output logic        vy_yaz_gecerli_o,
  output logic        vy_sec_o,
  input  logic [31:0] vy_veri_i,
  input  logic        vy_durdur_i,
  output logic        hata_o,
  output logic        hata_sahip_o
);

  localparam logic [7:0] ESIK = 8'(ZAMAN_ASIMI);

  durum_e     durum_q, durum_d;
  logic       oncelik_q, oncelik_d;
  logic       sahip_q, sahip_d;
  logic [7:0] sayac_q, sayac_d;
  logic       hata_q, hata_d;
  logic       hata_sahip_q, hata_sahip_d;
  logic       kazanan;
  logic       tamam;

  // Priority holder wins if it asks; otherwise the grant goes to the other side.
  assign kazanan = oncelik_q ? m1_sec_i : ~m0_sec_i;
  assign tamam   = (durum_q == AKTIF) && !vy_durdur_i;

  always_comb begin
    durum_d      = durum_q;
    oncelik_d    = oncelik_q;
    sahip_d      = sahip_q;
    sayac_d      = sayac_q;
    hata_d       = hata_q;
    hata_sahip_d = hata_sahip_q;
    unique case (durum_q)
      BOS: begin
        if (m0_sec_i || m1_sec_i) begin
          sahip_d = kazanan;
          sayac_d = '0;
          durum_d = AKTIF;
        end
      end
      AKTIF: begin
        if (sayac_q != 8'hFF) sayac_d = sayac_q + 8'd1;
        if (!vy_durdur_i) begin
          durum_d   = BOS;
          oncelik_d = ~sahip_q;
        end
      end
      default: durum_d = BOS;
    endcase
    // Only the first overrun is recorded; the transaction itself runs on.
    if ((sayac_q == ESIK) && !hata_q) begin
      hata_d       = 1'b1;
      hata_sahip_d = sahip_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      durum_q      <= BOS;
      oncelik_q    <= 1'b0;
      sahip_q      <= 1'b0;
      sayac_q      <= '0;
      hata_q       <= 1'b0;
      hata_sahip_q <= 1'b0;
    end else begin
      durum_q      <= durum_d;
      oncelik_q    <= oncelik_d;
      sahip_q      <= sahip_d;
      sayac_q      <= sayac_d;
      hata_q       <= hata_d;
      hata_sahip_q <= hata_sahip_d;
    end
  end

  always_comb begin
    vy_sec_o         = (durum_q == AKTIF);
    vy_adres_o       = '0;
    vy_veri_o        = '0;
    vy_veri_maske_o  = '0;
    vy_yaz_gecerli_o = 1'b0;
    if (durum_q == AKTIF) begin
      if (sahip_q) begin
        vy_adres_o       = m1_adres_i;
        vy_veri_o        = m1_veri_i;
        vy_veri_maske_o  = m1_veri_maske_i;
        vy_yaz_gecerli_o = m1_yaz_gecerli_i;
      end else begin
        vy_adres_o       = m0_adres_i;
        vy_veri_o        = m0_veri_i;
        vy_veri_maske_o  = m0_veri_maske_i;
        vy_yaz_gecerli_o = m0_yaz_gecerli_i;
      end
    end
  end

  assign m0_durdur_o  = m0_sec_i & ~(tamam && (sahip_q == 1'b0));
  assign m1_durdur_o  = m1_sec_i & ~(tamam && (sahip_q == 1'b1));
  assign m0_veri_o    = (sahip_q == 1'b0) ? vy_veri_i : 32'h0;
  assign m1_veri_o    = (sahip_q == 1'b1) ? vy_veri_i : 32'h0;
  assign hata_o       = hata_q;
  assign hata_sahip_o = hata_sahip_q;

endmodule

// File: tb/tb_veriyolu_hakem.sv
// Directed bench for veriyolu_hakem: reset, single read, contention,
// back-to-back alternation, timeout flag and asynchronous reset mid-transaction.
module tb_veriyolu_hakem;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [31:0] m0_adres, m0_veri, m1_adres, m1_veri;
  logic [3:0]  m0_maske, m1_maske;
  logic        m0_yaz, m1_yaz, m0_sec, m1_sec;
  logic [31:0] m0_veri_o, m1_veri_o;
  logic        m0_durdur, m1_durdur;
  logic [31:0] vy_adres, vy_veri;
  logic [3:0]  vy_maske;
  logic        vy_yaz, vy_sec;
  logic [31:0] vy_veri_i;
  logic        vy_durdur_i;
  logic        hata, hata_sahip;

  int vecCount  = 0;
  int missCount = 0;

  always #5 clk = ~clk;

  veriyolu_hakem #(.ZAMAN_ASIMI(4)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .m0_adres_i(m0_adres), .m0_veri_i(m0_veri), .m0_veri_maske_i(m0_maske),
    .m0_yaz_gecerli_i(m0_yaz), .m0_sec_i(m0_sec),
    .m0_veri_o(m0_veri_o), .m0_durdur_o(m0_durdur),
    .m1_adres_i(m1_adres), .m1_veri_i(m1_veri), .m1_veri_maske_i(m1_maske),
    .m1_yaz_gecerli_i(m1_yaz), .m1_sec_i(m1_sec),
    .m1_veri_o(m1_veri_o), .m1_durdur_o(m1_durdur),
    .vy_adres_o(vy_adres), .vy_veri_o(vy_veri), .vy_veri_maske_o(vy_maske),
    .vy_yaz_gecerli_o(vy_yaz), .vy_sec_o(vy_sec),
    .vy_veri_i(vy_veri_i), .vy_durdur_i(vy_durdur_i),
    .hata_o(hata), .hata_sahip_o(hata_sahip)
  );

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, actual=running required=done");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic do_reset();
    rst_ni = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    m0_adres = 32'h0; m0_veri = 32'h0; m0_maske = 4'h0; m0_yaz = 1'b0; m0_sec = 1'b1;
    m1_adres = 32'h0; m1_veri = 32'h0; m1_maske = 4'h0; m1_yaz = 1'b0; m1_sec = 1'b0;
    vy_veri_i = 32'h0; vy_durdur_i = 1'b1;
    rst_ni = 1'b0;
    @(negedge clk); #1;
    vecCount++; if (vy_sec !== 1'b0) begin missCount++; $display("[TB] FAIL reset_vy_sec actual=%b required=0", vy_sec); end
    vecCount++; if (hata !== 1'b0) begin missCount++; $display("[TB] FAIL reset_hata actual=%b required=0", hata); end
    vecCount++; if (hata_sahip !== 1'b0) begin missCount++; $display("[TB] FAIL reset_hata_sahip actual=%b required=0", hata_sahip); end
    vecCount++; if (m0_durdur !== 1'b1) begin missCount++; $display("[TB] FAIL reset_m0_durdur actual=%b required=1", m0_durdur); end
    vecCount++; if (m1_durdur !== 1'b0) begin missCount++; $display("[TB] FAIL reset_m1_durdur actual=%b required=0", m1_durdur); end
    vecCount++; if (vy_adres !== 32'h0) begin missCount++; $display("[TB] FAIL reset_vy_adres actual=%h required=0", vy_adres); end
    @(negedge clk);
    m0_sec = 1'b0;
    rst_ni = 1'b1;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    m0_adres = 32'h2000_0004; m0_yaz = 1'b0; m0_maske = 4'hF; m0_sec = 1'b1; vy_durdur_i = 1'b1;
    #1;
    vecCount++; if (vy_sec !== 1'b0) begin missCount++; $display("[TB] FAIL read_bos_vy_sec actual=%b required=0", vy_sec); end
    vecCount++; if (m0_durdur !== 1'b1) begin missCount++; $display("[TB] FAIL read_stall1 actual=%b required=1", m0_durdur); end
    @(negedge clk); #1;
    vecCount++; if (vy_sec !== 1'b1) begin missCount++; $display("[TB] FAIL read_vy_sec actual=%b required=1", vy_sec); end
    vecCount++; if (vy_adres !== 32'h2000_0004) begin missCount++; $display("[TB] FAIL read_vy_adres actual=%h required=20000004", vy_adres); end
    vecCount++; if (vy_yaz !== 1'b0) begin missCount++; $display("[TB] FAIL read_vy_yaz actual=%b required=0", vy_yaz); end
    vecCount++; if (m0_durdur !== 1'b1) begin missCount++; $display("[TB] FAIL read_stall2 actual=%b required=1", m0_durdur); end
    @(negedge clk);
    vy_durdur_i = 1'b0; vy_veri_i = 32'hA5A5_0001;
    #1;
    vecCount++; if (m0_durdur !== 1'b0) begin missCount++; $display("[TB] FAIL read_done_stall actual=%b required=0", m0_durdur); end
    vecCount++; if (m0_veri_o !== 32'hA5A5_0001) begin missCount++; $display("[TB] FAIL read_data actual=%h required=a5a50001", m0_veri_o); end
    @(negedge clk);
    m0_sec = 1'b0; vy_durdur_i = 1'b1; vy_veri_i = 32'h0;
    #1;
    vecCount++; if (vy_sec !== 1'b0) begin missCount++; $display("[TB] FAIL read_idle_after actual=%b required=0", vy_sec); end
  endtask

  task automatic test_contention();
    do_reset();
    @(negedge clk);
    m0_adres = 32'h0000_0100; m1_adres = 32'h0000_0200; m0_sec = 1'b1; m1_sec = 1'b1; vy_durdur_i = 1'b0;
    #1;
    vecCount++; if ({m0_durdur, m1_durdur} !== 2'b11) begin missCount++; $display("[TB] FAIL cont_bos_stalls actual=%b required=11", {m0_durdur, m1_durdur}); end
    @(negedge clk); #1;
    vecCount++; if (vy_sec !== 1'b1) begin missCount++; $display("[TB] FAIL cont_first_sec actual=%b required=1", vy_sec); end
    vecCount++; if (vy_adres !== 32'h0000_0100) begin missCount++; $display("[TB] FAIL cont_first_owner actual=%h required=00000100", vy_adres); end
    vecCount++; if ({m0_durdur, m1_durdur} !== 2'b01) begin missCount++; $display("[TB] FAIL cont_first_stalls actual=%b required=01", {m0_durdur, m1_durdur}); end
    @(negedge clk);
    m0_sec = 1'b0;
    #1;
    vecCount++; if (vy_sec !== 1'b0) begin missCount++; $display("[TB] FAIL cont_gap actual=%b required=0", vy_sec); end
    vecCount++; if (m1_durdur !== 1'b1) begin missCount++; $display("[TB] FAIL cont_gap_m1_stall actual=%b required=1", m1_durdur); end
    @(negedge clk); #1;
    vecCount++; if (vy_sec !== 1'b1) begin missCount++; $display("[TB] FAIL cont_second_sec actual=%b required=1", vy_sec); end
    vecCount++; if (vy_adres !== 32'h0000_0200) begin missCount++; $display("[TB] FAIL cont_second_owner actual=%h required=00000200", vy_adres); end
    vecCount++; if (m1_durdur !== 1'b0) begin missCount++; $display("[TB] FAIL cont_second_stall actual=%b required=0", m1_durdur); end
    @(negedge clk);
    m1_sec = 1'b0;
    #1;
    vecCount++; if (vy_sec !== 1'b0) begin missCount++; $display("[TB] FAIL cont_end_sec actual=%b required=0", vy_sec); end
  endtask

  task automatic test_back_to_back();
    int  c0 = 0, c1 = 0, t = 0;
    logic prevSec = 1'b0;
    logic needIdle = 1'b0;
    logic [31:0] expAddr, expData;
    vy_durdur_i = 1'b0;
    m0_yaz = 1'b1; m1_yaz = 1'b1; m0_maske = 4'hF; m1_maske = 4'h3;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      m0_sec = (c0 < 4); m0_adres = 32'h1000_0000 + 32'(4 * c0); m0_veri = 32'hD000_0000 + 32'(c0);
      m1_sec = (c1 < 4); m1_adres = 32'h2000_0000 + 32'(4 * c1); m1_veri = 32'hE000_0000 + 32'(c1);
      #1;
      if (needIdle) begin
        vecCount++; if (vy_sec !== 1'b0) begin missCount++; $display("[TB] FAIL b2b_idle_gap actual=%b required=0", vy_sec); end
      end
      if (vy_sec === 1'b1 && prevSec === 1'b0) begin
        expAddr = ((t % 2) == 1) ? 32'h2000_0000 + 32'(4 * (t / 2)) : 32'h1000_0000 + 32'(4 * (t / 2));
        expData = ((t % 2) == 1) ? 32'hE000_0000 + 32'(t / 2) : 32'hD000_0000 + 32'(t / 2);
        vecCount++; if (vy_adres !== expAddr) begin missCount++; $display("[TB] FAIL b2b_owner_addr t=%0d actual=%h required=%h", t, vy_adres, expAddr); end
        vecCount++; if (vy_veri !== expData) begin missCount++; $display("[TB] FAIL b2b_data t=%0d actual=%h required=%h", t, vy_veri, expData); end
        t++;
      end
      needIdle = vy_sec && !vy_durdur_i;
      prevSec  = vy_sec;
      if (m0_sec && !m0_durdur) c0++;
      if (m1_sec && !m1_durdur) c1++;
      if (c0 == 4 && c1 == 4 && !needIdle) break;
    end
    @(negedge clk);
    m0_sec = 1'b0; m1_sec = 1'b0; m0_yaz = 1'b0; m1_yaz = 1'b0; vy_durdur_i = 1'b1;
    vecCount++; if (t !== 8) begin missCount++; $display("[TB] FAIL b2b_count actual=%0d required=8", t); end
  endtask

  task automatic test_timeout();
    @(negedge clk);
    m1_adres = 32'h3000_0000; m1_sec = 1'b1; vy_durdur_i = 1'b1;
    #1;
    vecCount++; if (hata !== 1'b0) begin missCount++; $display("[TB] FAIL to_pre_hata actual=%b required=0", hata); end
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk); #1;
      vecCount++; if (vy_sec !== 1'b1) begin missCount++; $display("[TB] FAIL to_held_sec i=%0d actual=%b required=1", i, vy_sec); end
      vecCount++; if (hata !== (i >= 6)) begin missCount++; $display("[TB] FAIL to_hata i=%0d actual=%b required=%b", i, hata, (i >= 6)); end
      if (i == 6) begin
        vecCount++; if (hata_sahip !== 1'b1) begin missCount++; $display("[TB] FAIL to_hata_sahip actual=%b required=1", hata_sahip); end
      end
    end
    @(negedge clk);
    vy_durdur_i = 1'b0;
    #1;
    vecCount++; if (m1_durdur !== 1'b0) begin missCount++; $display("[TB] FAIL to_late_ack actual=%b required=0", m1_durdur); end
    @(negedge clk);
    m1_sec = 1'b0; vy_durdur_i = 1'b1;
    #1;
    vecCount++; if (vy_sec !== 1'b0) begin missCount++; $display("[TB] FAIL to_end_sec actual=%b required=0", vy_sec); end
    vecCount++; if (hata !== 1'b1) begin missCount++; $display("[TB] FAIL to_sticky actual=%b required=1", hata); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    m0_adres = 32'h4000_0008; m0_sec = 1'b1; vy_durdur_i = 1'b1;
    @(negedge clk); #1;
    vecCount++; if (vy_sec !== 1'b1) begin missCount++; $display("[TB] FAIL ar_active actual=%b required=1", vy_sec); end
    #1 rst_ni = 1'b0;
    #1;
    vecCount++; if (vy_sec !== 1'b0) begin missCount++; $display("[TB] FAIL ar_sec_drop actual=%b required=0", vy_sec); end
    vecCount++; if (hata !== 1'b0) begin missCount++; $display("[TB] FAIL ar_hata_clear actual=%b required=0", hata); end
    vecCount++; if (m0_durdur !== 1'b1) begin missCount++; $display("[TB] FAIL ar_stall actual=%b required=1", m0_durdur); end
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    vecCount++; if (vy_sec !== 1'b0) begin missCount++; $display("[TB] FAIL ar_bos actual=%b required=0", vy_sec); end
    @(negedge clk); #1;
    vecCount++; if (vy_adres !== 32'h4000_0008 || vy_sec !== 1'b1) begin missCount++; $display("[TB] FAIL ar_regrant actual=%h/%b required=40000008/1", vy_adres, vy_sec); end
    @(negedge clk);
    vy_durdur_i = 1'b0; vy_veri_i = 32'h1234_5678;
    #1;
    vecCount++; if (m0_durdur !== 1'b0 || m0_veri_o !== 32'h1234_5678) begin missCount++; $display("[TB] FAIL ar_complete actual=%b/%h required=0/12345678", m0_durdur, m0_veri_o); end
    @(negedge clk);
    m0_sec = 1'b0; vy_durdur_i = 1'b1;
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_single_read();
    test_contention();
    test_back_to_back();
    test_timeout();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
